// File: rtl/icache_responder.sv
// icache_responder: direct-mapped instruction cache for the pre-fetch req/addr_ok/data_ok protocol.
// Misses and uncached fetches are served over a simple read-burst port toward the AXI bridge.
`default_nettype none

module icache_responder #(
  parameter int SETS       = 256,
  parameter int LINE_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     icache_req,
  input  logic                     icache_iscache,
  input  logic [3:0]               icache_offset,
  input  logic [$clog2(SETS)-1:0]  icache_index,
  input  logic [19:0]              icache_tag,
  output logic                     icache_addr_ok,
  output logic                     icache_data_ok,
  output logic [31:0]              icache_rdata,
  input  logic                     inv_valid,
  input  logic [$clog2(SETS)-1:0]  inv_index,
  output logic                     inv_ready,
  output logic                     rd_req,
  output logic                     rd_type,
  output logic [31:0]              rd_addr,
  input  logic                     rd_rdy,
  input  logic                     ret_valid,
  input  logic                     ret_last,
  input  logic [31:0]              ret_data
);

  localparam int IDX_W = $clog2(SETS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_MISS    = 3'd2,
    S_REFILL  = 3'd3,
    S_RESPOND = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               cached_q;
  logic [3:0]         off_q;
  logic [IDX_W-1:0]   idx_q;
  logic [19:0]        tag_q;
  logic [1:0]         cnt_q;
  logic [SETS-1:0]    valid_q;
  logic [19:0]        tag_arr    [SETS];
  logic [31:0]        data_arr   [SETS][LINE_WORDS];
  logic [31:0]        line_buf_q [LINE_WORDS];

  logic hit;
  logic beat;
  logic fill_done;

  assign hit       = cached_q && valid_q[idx_q] && (tag_arr[idx_q] == tag_q);
  assign beat      = (state_q == S_REFILL) && ret_valid;
  assign fill_done = beat && ret_last;

  always_comb begin
    state_d        = state_q;
    icache_addr_ok = 1'b0;
    icache_data_ok = 1'b0;
    icache_rdata   = 32'h0;
    inv_ready      = 1'b0;
    rd_req         = 1'b0;
    rd_type        = 1'b0;
    rd_addr        = 32'h0;
    case (state_q)
      S_IDLE: begin
        inv_ready = 1'b1;
        // An invalidate wins the cycle; the fetch is retried by the requester.
        if (!inv_valid && icache_req) begin
          icache_addr_ok = 1'b1;
          state_d        = icache_iscache ? S_LOOKUP : S_MISS;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          icache_data_ok = 1'b1;
          icache_rdata   = data_arr[idx_q][off_q[3:2]];
          icache_addr_ok = icache_req;
          if (icache_req) state_d = icache_iscache ? S_LOOKUP : S_MISS;
          else            state_d = S_IDLE;
        end else begin
          state_d = S_MISS;
        end
      end
      S_MISS: begin
        rd_req  = 1'b1;
        rd_type = cached_q;
        rd_addr = cached_q ? {tag_q, idx_q, 4'h0} : {tag_q, idx_q, off_q};
        if (rd_rdy) state_d = S_REFILL;
      end
      S_REFILL: begin
        if (fill_done) state_d = S_RESPOND;
      end
      S_RESPOND: begin
        icache_data_ok = 1'b1;
        icache_rdata   = cached_q ? line_buf_q[off_q[3:2]] : line_buf_q[0];
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are forced quiet for the whole time reset is held, not just after the edge.
    if (reset) begin
      icache_addr_ok = 1'b0;
      icache_data_ok = 1'b0;
      icache_rdata   = 32'h0;
      inv_ready      = 1'b0;
      rd_req         = 1'b0;
      rd_type        = 1'b0;
      rd_addr        = 32'h0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      valid_q  <= '0;
      cnt_q    <= 2'd0;
      cached_q <= 1'b0;
      off_q    <= 4'h0;
      idx_q    <= '0;
      tag_q    <= 20'h0;
    end else begin
      state_q <= state_d;
      if (icache_addr_ok) begin
        cached_q <= icache_iscache;
        off_q    <= icache_offset;
        idx_q    <= icache_index;
        tag_q    <= icache_tag;
      end
      if (state_q == S_IDLE && inv_valid) valid_q[inv_index] <= 1'b0;
      if (state_q == S_MISS && rd_rdy) cnt_q <= 2'd0;
      if (beat) cnt_q <= cnt_q + 2'd1;
      if (fill_done && cached_q) valid_q[idx_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (beat) begin
      line_buf_q[cnt_q] <= ret_data;
      // The last beat is still in flight, so the line is assembled from the buffer plus ret_data.
      if (ret_last && cached_q) begin
        tag_arr[idx_q] <= tag_q;
        for (int w = 0; w < LINE_WORDS; w++) begin
          data_arr[idx_q][w] <= (w == int'(cnt_q)) ? ret_data : line_buf_q[w];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_icache_responder.sv
// tb_icache_responder: directed and randomized fetches checked against a behavioural cache/memory model.
`default_nettype none

module tb_icache_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        icache_req, icache_iscache;
  logic [3:0]  icache_offset;
  logic [7:0]  icache_index;
  logic [19:0] icache_tag;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic        inv_valid;
  logic [7:0]  inv_index;
  logic        inv_ready;
  logic        rd_req, rd_type;
  logic [31:0] rd_addr;
  logic        rd_rdy, ret_valid, ret_last;
  logic [31:0] ret_data;

  always #5 clk = ~clk;

  icache_responder dut (
    .clk(clk), .reset(reset),
    .icache_req(icache_req), .icache_iscache(icache_iscache),
    .icache_offset(icache_offset), .icache_index(icache_index), .icache_tag(icache_tag),
    .icache_addr_ok(addr_ok), .icache_data_ok(data_ok), .icache_rdata(rdata),
    .inv_valid(inv_valid), .inv_index(inv_index), .inv_ready(inv_ready),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data)
  );

  int n_total = 0;
  int n_pass  = 0;
  int refills = 0;

  // Model: what the cache should hold, and what memory returns per word address.
  bit          mv [256];
  logic [19:0] mt [256];
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", name, obs, exp);
  endtask

  // rst_mode: 0 = normal, 1 = reset while rd_req is up, 2 = reset after the 2nd return beat.
  task automatic fetch(input bit c, input logic [19:0] t, input logic [7:0] i, input logic [3:0] o,
                       input int rst_mode, output logic [31:0] got);
    bit          hit;
    int          nb, n;
    logic [31:0] a;
    got = 32'h0;
    hit = c && mv[i] && (mt[i] == t);
    a   = c ? {t, i, 4'h0} : {t, i, o};
    @(negedge clk);
    inv_valid = 0; icache_req = 1; icache_iscache = c;
    icache_tag = t; icache_index = i; icache_offset = o;
    #1 chk("addr_ok", addr_ok, 1);
    @(negedge clk);
    icache_req = 0;
    #1;
    if (hit) begin
      chk("hit_data_ok", data_ok, 1);
      chk("hit_rdata", rdata, memword({t, i, o[3:2], 2'b00}));
      got = rdata;
      return;
    end
    chk("miss_no_data_ok", data_ok, 0);
    n = 0;
    while (!rd_req && n < 6) begin
      @(negedge clk); #1; n++;
    end
    if (!rd_req) begin
      chk("rd_req_timeout", 0, 1);
      return;
    end
    chk("rd_type", rd_type, c);
    chk("rd_addr", rd_addr, a);
    if (rst_mode == 1) begin
      icache_req = 1; reset = 1;
      #1 chk("rst_miss_rd_req", rd_req, 0);
      chk("rst_miss_addr_ok", addr_ok, 0);
      @(negedge clk); reset = 0; icache_req = 0;
      mv = '{default: 0};
      return;
    end
    // Stray return beats before the handshake must be ignored.
    repeat ($urandom_range(0, 2)) begin
      ret_valid = 1; ret_last = 1; ret_data = $urandom;
      @(negedge clk);
      ret_valid = 0; ret_last = 0;
      #1 chk("rd_req_held", rd_req, 1);
    end
    rd_rdy = 1;
    @(negedge clk);
    rd_rdy = 0;
    refills++;
    nb = c ? 4 : 1;
    for (int b = 0; b < nb; b++) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      ret_valid = 1; ret_last = (b == nb - 1);
      ret_data  = memword(c ? {t, i, b[1:0], 2'b00} : a);
      @(negedge clk);
      ret_valid = 0; ret_last = 0;
      if (rst_mode == 2 && b == 1) begin
        icache_req = 1; reset = 1;
        #1 chk("rst_fill_rd_req", rd_req, 0);
        chk("rst_fill_data_ok", data_ok, 0);
        chk("rst_fill_addr_ok", addr_ok, 0);
        @(negedge clk); reset = 0; icache_req = 0;
        mv = '{default: 0};
        return;
      end
    end
    #1 chk("resp_data_ok", data_ok, 1);
    chk("resp_inv_ready", inv_ready, 0);
    chk("resp_addr_ok", addr_ok, 0);
    chk("resp_rdata", rdata, c ? memword({t, i, o[3:2], 2'b00}) : memword(a));
    got = rdata;
    if (c) begin
      mv[i] = 1; mt[i] = t;
    end
  endtask

  task automatic do_inv(input logic [7:0] i, input bit with_req);
    @(negedge clk);
    inv_valid = 1; inv_index = i;
    icache_req = with_req; icache_iscache = 1; icache_index = i; icache_offset = 4'h0;
    #1 chk("inv_ready", inv_ready, 1);
    chk("inv_blocks_addr_ok", addr_ok, 0);
    mv[i] = 0;
    @(negedge clk);
    inv_valid = 0; icache_req = 0;
  endtask

  logic [31:0] got;
  int          r0;

  initial begin
    reset = 1; icache_req = 1; icache_iscache = 1; icache_offset = 0;
    icache_index = 0; icache_tag = 0; inv_valid = 0; inv_index = 0;
    rd_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = 0;
    mv = '{default: 0};
    @(negedge clk);
    #1;
    chk("reset_addr_ok", addr_ok, 0);
    chk("reset_data_ok", data_ok, 0);
    chk("reset_inv_ready", inv_ready, 0);
    chk("reset_rd_req", rd_req, 0);
    chk("reset_rd_addr", rd_addr, 0);
    chk("reset_rdata", rdata, 0);
    @(negedge clk);
    reset = 0; icache_req = 0;

    // Cold miss
    mem[32'h1FC00000] = 32'h11; mem[32'h1FC00004] = 32'h22;
    mem[32'h1FC00008] = 32'h33; mem[32'h1FC0000C] = 32'h44;
    fetch(1, 20'h1FC00, 8'h00, 4'h4, 0, got);
    chk("cold_rdata", got, 32'h22);

    // Back-to-back pipelined hits
    @(negedge clk);
    icache_req = 1; icache_iscache = 1; icache_tag = 20'h1FC00; icache_index = 0; icache_offset = 4'h0;
    #1 chk("b2b_addr_ok0", addr_ok, 1);
    @(negedge clk); icache_offset = 4'h8;
    #1 chk("b2b_data_ok0", data_ok, 1); chk("b2b_rdata0", rdata, 32'h11); chk("b2b_addr_ok1", addr_ok, 1);
    @(negedge clk); icache_offset = 4'hC;
    #1 chk("b2b_rdata1", rdata, 32'h33); chk("b2b_addr_ok2", addr_ok, 1); chk("b2b_no_rd_req", rd_req, 0);
    @(negedge clk); icache_req = 0;
    #1 chk("b2b_data_ok2", data_ok, 1); chk("b2b_rdata2", rdata, 32'h44); chk("b2b_addr_ok_off", addr_ok, 0);
    @(negedge clk);
    #1 chk("b2b_idle_data_ok", data_ok, 0);

    // Uncached, then a cached fetch to the same index still misses
    mem[32'h1FC00378] = 32'hDEADBEEF;
    fetch(0, 20'h1FC00, 8'h37, 4'h8, 0, got);
    chk("unc_rdata", got, 32'hDEADBEEF);
    r0 = refills;
    fetch(1, 20'h1FC00, 8'h37, 4'h0, 0, got);
    chk("unc_then_cached_refills", refills - r0, 1);

    // Invalidate has priority over a same-cycle request
    do_inv(8'h00, 1);
    r0 = refills;
    fetch(1, 20'h1FC00, 8'h00, 4'h0, 0, got);
    chk("inv_refills", refills - r0, 1);
    chk("inv_rdata", got, 32'h11);

    // Reset while rd_req is up, then reset mid-refill
    fetch(1, 20'h00ABC, 8'h55, 4'h0, 1, got);
    fetch(1, 20'h12345, 8'h00, 4'h0, 2, got);
    r0 = refills;
    fetch(1, 20'h1FC00, 8'h00, 4'h4, 0, got);
    chk("post_reset_refills", refills - r0, 1);
    chk("post_reset_rdata", got, 32'h22);

    // Tag conflict on one set
    fetch(1, 20'hA0000, 8'h10, 4'h0, 0, got);
    r0 = refills;
    fetch(1, 20'hB0000, 8'h10, 4'h4, 0, got);
    fetch(1, 20'hA0000, 8'h10, 4'h8, 0, got);
    chk("conflict_refills", refills - r0, 2);

    // Randomized mix over a small address pool so hits, conflicts and invalidates all occur
    for (int k = 0; k < 200; k++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0)
        do_inv(8'h40 + 8'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      else
        fetch(sel != 1, 20'h30000 + 20'($urandom_range(0, 2)), 8'h40 + 8'($urandom_range(0, 3)),
              4'($urandom_range(0, 15)), 0, got);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
